// File: rtl/chimera_clu_pwr_seq.sv
// Per-cluster power/isolation sequencer: walks one cluster domain through clock-up,
// reset release and de-isolation on enable, and the mirror sequence on disable.
`timescale 1ns/1ps
module chimera_clu_pwr_seq #(
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned RstCycles       = 8,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic       soc_clk_i,
  input  logic       rst_ni,
  input  logic       en_req_i,
  input  logic       isolated_i,
  input  logic       err_clr_i,
  output logic       isolate_o,
  output logic       clk_en_o,
  output logic       rst_no,
  output logic       on_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  localparam int unsigned MaxClkRst = (ClkSettleCycles > RstCycles) ? ClkSettleCycles : RstCycles;
  localparam int unsigned MaxCycles = (MaxClkRst > TimeoutCycles) ? MaxClkRst : TimeoutCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] ClkLast  = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] RstLast  = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] TimeLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax   = '1;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    CLK_UP   = 3'd1,
    RST_REL  = 3'd2,
    DEISO    = 3'd3,
    ON       = 3'd4,
    ISO      = 3'd5,
    RST_ASRT = 3'd6
  } state_e;

  state_e            state_reg;
  state_e            state_next;
  logic [CntW-1:0]   cnt_reg;
  logic [CntW-1:0]   cnt_next;
  logic              timeout_reg;
  logic              timeout_set;
  logic [3:0]        outs_reg;

  // {isolate, clk_en, rst_n, on} for each state; the unused encoding looks like OFF.
  function automatic logic [3:0] decode_outs(input state_e s);
    logic [3:0] o;
    o = 4'b1000;
    case (s)
      OFF:      o = 4'b1000;
      CLK_UP:   o = 4'b1100;
      RST_REL:  o = 4'b1110;
      DEISO:    o = 4'b0110;
      ON:       o = 4'b0111;
      ISO:      o = 4'b1110;
      RST_ASRT: o = 4'b1100;
      default:  o = 4'b1000;
    endcase
    return o;
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OFF:      if (en_req_i)            state_next = CLK_UP;
      CLK_UP:   if (cnt_reg == ClkLast)  state_next = RST_REL;
      RST_REL:  if (cnt_reg == RstLast)  state_next = DEISO;
      DEISO:    if (!isolated_i)         state_next = ON;
      ON:       if (!en_req_i)           state_next = ISO;
      ISO:      if (isolated_i)          state_next = RST_ASRT;
      RST_ASRT: if (cnt_reg == RstLast)  state_next = OFF;
      default:                           state_next = OFF;
    endcase
  end

  // One shared counter: restarts on any state change, saturates instead of wrapping.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (cnt_reg != CntMax) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Timeout fires on the cycle the isolation wait completes its budget without an answer.
  always_comb begin
    timeout_set = 1'b0;
    if (((state_reg == DEISO) || (state_reg == ISO)) &&
        (state_next == state_reg) && (cnt_reg == TimeLast)) begin
      timeout_set = 1'b1;
    end
  end

  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= OFF;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
      outs_reg    <= 4'b1000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      outs_reg  <= decode_outs(state_next);
      if (timeout_set) begin
        timeout_reg <= 1'b1;
      end else if (err_clr_i) begin
        timeout_reg <= 1'b0;
      end
    end
  end

  assign isolate_o = outs_reg[3];
  assign clk_en_o  = outs_reg[2];
  assign rst_no    = outs_reg[1];
  assign on_o      = outs_reg[0];
  assign timeout_o = timeout_reg;
  assign state_o   = state_reg;

endmodule

// File: doc/chimera_clu_pwr_seq.md
CHIMERA_CLU_PWR_SEQ -- requirements
Module: chimera_clu_pwr_seq

Purpose: per-cluster power/isolation sequencer. Drives one cluster's isolate request, clock enable and reset into the cluster domain, and consumes that domain's isolated status.

Interface
REQ-001 SHALL have parameter ClkSettleCycles, default 4, cycles clock runs before reset release (>=1).
REQ-002 SHALL have parameter RstCycles, default 8, cycles reset is held with clock running, on both power-up and power-down (>=1).
REQ-003 SHALL have parameter TimeoutCycles, default 1024, cycles in an isolation transition before timeout flag (>=1).
REQ-004 SHALL have port soc_clk_i, input, 1, the only clock; all logic is single-clock.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port en_req_i, input, 1, level request: 1 = cluster on, 0 = cluster off.
REQ-007 SHALL have port isolated_i, input, 1, isolation-complete status from the cluster domain.
REQ-008 SHALL have port err_clr_i, input, 1, clears timeout_o.
REQ-009 SHALL have port isolate_o, output, 1, isolation request to the cluster domain.
REQ-010 SHALL have port clk_en_o, output, 1, cluster clock-gate enable.
REQ-011 SHALL have port rst_no, output, 1, cluster reset, active-low.
REQ-012 SHALL have port on_o, output, 1, cluster operational and de-isolated.
REQ-013 SHALL have port timeout_o, output, 1, sticky isolation-transition timeout flag.
REQ-014 SHALL have port state_o, output, 3, current FSM state encoding.

Function
REQ-015 SHALL implement states OFF=0, CLK_UP=1, RST_REL=2, DEISO=3, ON=4, ISO=5, RST_ASRT=6; encoding 7 is unreachable and SHALL map to OFF.
REQ-016 All outputs SHALL be Moore outputs decoded from registered state; no combinational path from any input to any output.
REQ-017 Output decode {isolate_o, clk_en_o, rst_no, on_o}: OFF=1000, CLK_UP=1100, RST_REL=1110, DEISO=0110, ON=0111, ISO=1110, RST_ASRT=1100.
REQ-018 OFF: en_req_i=1 -> CLK_UP on the next edge, counter cleared.
REQ-019 CLK_UP: held exactly ClkSettleCycles cycles, then RST_REL.
REQ-020 RST_REL: held exactly RstCycles cycles, then DEISO.
REQ-021 DEISO: isolated_i=0 -> ON on the next edge; minimum dwell is 1 cycle, even when isolated_i is already 0 on entry.
REQ-022 ON: en_req_i=0 -> ISO on the next edge.
REQ-023 ISO: isolated_i=1 -> RST_ASRT on the next edge; en_req_i is ignored in ISO (no abort).
REQ-024 RST_ASRT: held exactly RstCycles cycles, then OFF.
REQ-025 en_req_i changes during CLK_UP/RST_REL/DEISO SHALL NOT abort the power-up; the sequence completes to ON, and ON then reacts to en_req_i.
REQ-026 Single shared counter, width $clog2(max(ClkSettleCycles,RstCycles,TimeoutCycles)+1); it SHALL clear on every state change and saturate at its maximum value, never wrapping.
REQ-027 In DEISO and ISO, when the counter reaches TimeoutCycles, timeout_o SHALL be set; the state SHALL remain unchanged and keep waiting on isolated_i.
REQ-028 timeout_o SHALL be sticky; err_clr_i clears it on the next edge; if set and clear occur in the same cycle, set wins.

Reset
REQ-029 rst_ni=0 SHALL asynchronously force state=OFF, counter=0, timeout_o=0, hence isolate_o=1, clk_en_o=0, rst_no=0, on_o=0, state_o=0, from any state including mid-sequence.
REQ-030 After rst_ni deasserts, the first state change SHALL occur no earlier than the first rising edge with rst_ni=1.

Verification
REQ-031 Reset release, en_req_i=1 sampled at edge 0, isolated_i falls 2 cycles after DEISO entry -> clk_en_o=1 in cycles 1-4 with rst_no=0; rst_no=1 from cycle 5; isolate_o=0 from cycle 13; on_o=1 from cycle 16.
REQ-032 In ON, en_req_i=0 at edge t, isolated_i=1 at t+20 -> isolate_o=1 from t+1; rst_no=0 with clk_en_o=1 for 8 cycles starting t+22; then clk_en_o=0, state_o=0.
REQ-033 In ISO, isolated_i held 0 -> timeout_o=1 after 1024 cycles in ISO, state_o stays 5; isolated_i=1 -> proceeds to RST_ASRT; err_clr_i pulse -> timeout_o=0 next cycle.
REQ-034 en_req_i dropped to 0 during RST_REL -> sequence reaches ON (on_o=1 for exactly 1 cycle), then ISO.
REQ-035 rst_ni asserted mid-cycle while in ON with timeout_o=1 -> immediately, before the next edge, isolate_o=1, clk_en_o=0, rst_no=0, on_o=0, timeout_o=0.
REQ-036 isolated_i already 0 on DEISO entry -> state_o=3 for exactly 1 cycle, then 4.
